// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared types and constants for the round-robin 4-to-1 mux arbiter.
package rr_mux4_arbiter_pkg;

    localparam int unsigned REQ_W = 4;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] SEL_I0 = 2'd0;
    localparam logic [SEL_W-1:0] SEL_I1 = 2'd1;
    localparam logic [SEL_W-1:0] SEL_I2 = 2'd2;
    localparam logic [SEL_W-1:0] SEL_I3 = 2'd3;

    // One-hot grant vector for a mux select code.
    function automatic logic [REQ_W-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        return REQ_W'(1) << sel;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request at or after start, wrapping.
module rr_pick4
    import rr_mux4_arbiter_pkg::*;
(
    input  logic [REQ_W-1:0] req,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    logic [SEL_W-1:0] idx;
    logic             found;

    always_comb begin
        winner = start;
        found  = 1'b0;
        idx    = start;
        for (int unsigned k = 0; k < REQ_W; k++) begin
            idx = start + SEL_W'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter driving the select pair of a shared 4-to-1 mux,
// with a hold limit that forces rotation while others are waiting.
module rr_mux4_arbiter
    import rr_mux4_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REQ_W-1:0] req,
    output logic [REQ_W-1:0] gnt,
    output logic             s1,
    output logic             s0,
    output logic             valid
);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0]  hold_q, hold_d;
    logic [REQ_W-1:0]  gnt_d;
    logic              s1_d, s0_d, valid_d;

    logic [SEL_W-1:0]  start_c;
    logic [SEL_W-1:0]  winner_c;
    logic              any_c;
    logic              others_c;
    logic              take;

    // Search always begins just after the most recent winner.
    assign start_c  = last_q + SEL_W'(1);
    assign others_c = |(req & ~sel_onehot(last_q));

    rr_pick4 u_pick (
        .req    (req),
        .start  (start_c),
        .winner (winner_c),
        .any    (any_c)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= SEL_I3;
            hold_q  <= '0;
            gnt     <= '0;
            s1      <= SEL_I0[1];
            s0      <= SEL_I0[0];
            valid   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            gnt     <= gnt_d;
            s1      <= s1_d;
            s0      <= s0_d;
            valid   <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        gnt_d   = gnt;
        s1_d    = s1;
        s0_d    = s0;
        valid_d = valid;
        take    = 1'b0;

        case (state_q)
            IDLE: begin
                gnt_d   = '0;
                valid_d = 1'b0;
                take    = any_c;
            end
            GRANT: begin
                if (!req[last_q]) begin
                    if (others_c) begin
                        take = 1'b1;
                    end else begin
                        gnt_d   = '0;
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end else if (hold_q == CNT_W'(MAX_HOLD)) begin
                    // Saturated: rotate only if someone else is waiting.
                    take = others_c;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take) begin
            state_d      = GRANT;
            gnt_d        = sel_onehot(winner_c);
            {s1_d, s0_d} = winner_c;
            valid_d      = 1'b1;
            last_d       = winner_c;
            hold_d       = CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Scoreboard bench for rr_mux4_arbiter: a behavioural model queues expected
// outputs per cycle; each scenario task pops and compares after the edge.
module tb_rr_mux4_arbiter;

    localparam int MAX_HOLD = 4;
    localparam int WAIT_MAX = 3 * MAX_HOLD + 3;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = 4'b0000;
    logic [3:0] gnt;
    logic       s1, s0, valid;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int         m_owner = -1;
    int         m_last  = 3;
    int         m_hold  = 0;
    logic [3:0] m_gnt   = 4'b0000;
    logic [1:0] m_sel   = 2'b00;
    logic       m_valid = 1'b0;

    rr_mux4_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .gnt   (gnt),
        .s1    (s1),
        .s0    (s0),
        .valid (valid)
    );

    always #5 clock = ~clock;

    task automatic model_take(input int n);
        m_owner = n;
        m_last  = n;
        m_hold  = 1;
        m_gnt   = 4'(1 << n);
        m_sel   = 2'(n);
        m_valid = 1'b1;
    endtask

    // Behavioural reference: advance one clock edge.
    task automatic model_step(input logic rst, input logic [3:0] rq);
        int nxt;
        int idx;
        if (rst) begin
            m_owner = -1; m_last = 3; m_hold = 0;
            m_gnt = 4'b0000; m_sel = 2'b00; m_valid = 1'b0;
            return;
        end
        nxt = -1;
        for (int k = 1; k <= 4; k++) begin
            idx = (m_last + k) % 4;
            if (nxt < 0 && rq[idx]) nxt = idx;
        end
        if (m_owner < 0) begin
            if (nxt >= 0) model_take(nxt);
            else begin m_gnt = 4'b0000; m_valid = 1'b0; end
        end else if (!rq[m_owner]) begin
            if (nxt >= 0) model_take(nxt);
            else begin m_owner = -1; m_gnt = 4'b0000; m_valid = 1'b0; end
        end else if (m_hold == MAX_HOLD && nxt != m_owner) begin
            model_take(nxt);
        end else if (m_hold < MAX_HOLD) begin
            m_hold++;
        end
    endtask

    // Drive one cycle of stimulus, queue its expected result, settle past the edge.
    task automatic drive(input logic rst, input logic [3:0] rq);
        @(negedge clock);
        reset = rst;
        req   = rq;
        model_step(rst, rq);
        expq.push_back({m_gnt, m_sel, m_valid});
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, o;
        for (int i = 0; i < 4; i++) begin
            drive(i < 2, 4'b0000);
            e = expq.pop_front(); o = {gnt, s1, s0, valid};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset_idle[%0d]: got gnt=%b sel=%b valid=%b, want gnt=%b sel=%b valid=%b",
                         i, o.gnt, o.sel, o.valid, e.gnt, e.sel, e.valid);
            end
            n_cmp++;
            if (o !== 7'b0000_00_0) begin
                n_bad++;
                $display("FAIL reset_const[%0d]: got %b, want 0000_00_0", i, o);
            end
        end
    endtask

    task automatic test_single();
        exp_t e, o;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, (i < 6) ? 4'b0100 : 4'b0000);
            e = expq.pop_front(); o = {gnt, s1, s0, valid};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL single[%0d]: got gnt=%b sel=%b valid=%b, want gnt=%b sel=%b valid=%b",
                         i, o.gnt, o.sel, o.valid, e.gnt, e.sel, e.valid);
            end
            n_cmp++;
            if (o !== ((i < 6) ? 7'b0100_10_1 : 7'b0000_10_0)) begin
                n_bad++;
                $display("FAIL single_const[%0d]: got %b", i, o);
            end
        end
    endtask

    task automatic test_all_request();
        exp_t e, o, w;
        int   own;
        drive(1'b1, 4'b0000);
        e = expq.pop_front(); o = {gnt, s1, s0, valid};
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL all_req_reset: got %b, want %b", o, e);
        end
        for (int k = 1; k <= 17; k++) begin
            drive(1'b0, 4'b1111);
            e = expq.pop_front(); o = {gnt, s1, s0, valid};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL all_req[%0d]: got gnt=%b sel=%b valid=%b, want gnt=%b sel=%b valid=%b",
                         k, o.gnt, o.sel, o.valid, e.gnt, e.sel, e.valid);
            end
            own = ((k - 1) / MAX_HOLD) % 4;
            w   = {4'(1 << own), 2'(own), 1'b1};
            n_cmp++;
            if (o !== w) begin
                n_bad++;
                $display("FAIL all_req_const[%0d]: got %b, want %b", k, o, w);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, o;
        logic [3:0] seq [4];
        seq[0] = 4'b0000; seq[1] = 4'b0010; seq[2] = 4'b1010; seq[3] = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            drive(i == 0, seq[i]);
            e = expq.pop_front(); o = {gnt, s1, s0, valid};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL b2b[%0d]: got gnt=%b sel=%b valid=%b, want gnt=%b sel=%b valid=%b",
                         i, o.gnt, o.sel, o.valid, e.gnt, e.sel, e.valid);
            end
        end
        n_cmp++;
        if ({gnt, s1, s0, valid} !== 7'b1000_11_1) begin
            n_bad++;
            $display("FAIL b2b_no_bubble: got %b, want 1000_11_1", {gnt, s1, s0, valid});
        end
    endtask

    task automatic test_reset_mid();
        exp_t e, o;
        for (int i = 0; i < 12; i++) begin
            drive(i == 0 || i == 10, (i == 0) ? 4'b0000 : 4'b1111);
            e = expq.pop_front(); o = {gnt, s1, s0, valid};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset_mid[%0d]: got gnt=%b sel=%b valid=%b, want gnt=%b sel=%b valid=%b",
                         i, o.gnt, o.sel, o.valid, e.gnt, e.sel, e.valid);
            end
            if (i == 9 || i == 10 || i == 11) begin
                e = (i == 9) ? 7'b0100_10_1 : (i == 10) ? 7'b0000_00_0 : 7'b0001_00_1;
                n_cmp++;
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL reset_mid_const[%0d]: got %b, want %b", i, o, e);
                end
            end
        end
    endtask

    task automatic test_fairness();
        exp_t       e, o;
        logic [3:0] r;
        int         waits [4];
        int         worst;
        int         gi;
        for (int i = 0; i < 4; i++) waits[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            r = req;
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    if (gnt[i] && $urandom_range(2) == 0) r[i] = 1'b0;
                end else if ($urandom_range(1) == 1) begin
                    r[i] = 1'b1;
                end
            end
            drive(1'b0, r);
            e = expq.pop_front(); o = {gnt, s1, s0, valid};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL fair_model[%0d]: req=%b got gnt=%b sel=%b valid=%b, want gnt=%b sel=%b valid=%b",
                         c, r, o.gnt, o.sel, o.valid, e.gnt, e.sel, e.valid);
            end
            gi = 0;
            for (int i = 0; i < 4; i++) if (gnt[i]) gi = i;
            n_cmp++;
            if ($countones(gnt) > 1 || valid !== (gnt != 4'b0000) || (valid && {s1, s0} !== 2'(gi))) begin
                n_bad++;
                $display("FAIL fair_invariant[%0d]: gnt=%b sel=%b%b valid=%b", c, gnt, s1, s0, valid);
            end
            worst = 0;
            for (int i = 0; i < 4; i++) begin
                waits[i] = (req[i] && !gnt[i]) ? waits[i] + 1 : 0;
                if (waits[i] > worst) worst = waits[i];
            end
            n_cmp++;
            if (worst > WAIT_MAX) begin
                n_bad++;
                $display("FAIL fair_wait[%0d]: waited %0d cycles, limit %0d", c, worst, WAIT_MAX);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_request();
        test_back_to_back();
        test_reset_mid();
        test_fairness();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
